// File: rtl/led_seq_ctrl_if.sv
// Configuration port for led_seq_ctrl.
// A valid/ready handshake carries a new pattern mode and tick rate into the sequencer.
//   cfg_valid  master -> slave  configuration offered
//   cfg_ready  slave -> master  configuration can be accepted
//   cfg_mode   master -> slave  0 blink, 1 chase, 2 bounce, 3 count
//   cfg_rate   master -> slave  tick period exponent (period = 2^rate cycles)
interface led_seq_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [4:0] cfg_rate;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_rate,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_rate,
        output cfg_ready
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: a prescaler produces a programmable tick and each tick steps one of
// four LED patterns (blink, chase, bounce, binary count). New configuration is accepted
// directly while idle and is deferred to the next tick boundary while running.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   en     run enable; low forces idle
//   hold   freeze prescaler and pattern while running
//   cfg    configuration handshake (slave side)
//   led    registered LED drive
//   tick   one-cycle pulse coincident with each led update
//   busy   high whenever the sequencer is not idle
module led_seq_ctrl #(
    parameter int unsigned CNT_W   = 26,
    parameter int unsigned NUM_LED = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hold,
    led_seq_ctrl_if.slave      cfg,
    output logic [NUM_LED-1:0] led,
    output logic               tick,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    localparam logic [4:0] RateMax = 5'(CNT_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [4:0]         rate_q, rate_d;
    logic [1:0]         shadow_mode_q, shadow_mode_d;
    logic [4:0]         shadow_rate_q, shadow_rate_d;
    logic               pending_q, pending_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               tick_q, tick_d;
    logic               dir_up_q, dir_up_d;

    logic               accept;
    logic [4:0]         rate_clamped;
    logic [CNT_W-1:0]   cnt_max;
    logic [NUM_LED-1:0] bounce_next;

    // Chase and bounce start on bit 0; blink and count start from all-zero.
    function automatic logic [NUM_LED-1:0] init_pattern(input logic [1:0] mode);
        return (mode == 2'd1 || mode == 2'd2) ? NUM_LED'(1) : '0;
    endfunction

    assign accept       = cfg.cfg_valid && cfg.cfg_ready;
    assign rate_clamped = (cfg.cfg_rate > RateMax) ? RateMax : cfg.cfg_rate;
    assign cnt_max      = (CNT_W'(1) << rate_q) - CNT_W'(1);
    assign bounce_next  = dir_up_q ? (led_q << 1) : (led_q >> 1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        rate_d        = rate_q;
        shadow_mode_d = shadow_mode_q;
        shadow_rate_d = shadow_rate_q;
        pending_d     = pending_q;
        led_d         = led_q;
        tick_d        = 1'b0;
        dir_up_d      = dir_up_q;

        unique case (state_q)
            StIdle:  if (en)    state_d = StRun;
            StRun:   if (hold)  state_d = StHold;
            StHold:  if (!hold) state_d = StRun;
            default:            state_d = StIdle;
        endcase
        if (!en) state_d = StIdle;

        if (!en) begin
            // Leaving (or staying in) idle: any configuration lands in the active registers.
            cnt_d     = '0;
            led_d     = '0;
            pending_d = 1'b0;
            if (accept) begin
                mode_d = cfg.cfg_mode;
                rate_d = rate_clamped;
            end else if (pending_q) begin
                mode_d = shadow_mode_q;
                rate_d = shadow_rate_q;
            end
        end else if (state_q == StIdle) begin
            if (accept) begin
                mode_d = cfg.cfg_mode;
                rate_d = rate_clamped;
            end
            cnt_d    = '0;
            led_d    = init_pattern(mode_d);
            dir_up_d = 1'b1;
        end else begin
            if (accept) begin
                shadow_mode_d = cfg.cfg_mode;
                shadow_rate_d = rate_clamped;
                pending_d     = 1'b1;
            end
            // hold gates counting on the same edge it is sampled, so no count is lost.
            if (!hold) begin
                if (cnt_q == cnt_max) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;
                    if (pending_q) begin
                        mode_d    = shadow_mode_q;
                        rate_d    = shadow_rate_q;
                        pending_d = 1'b0;
                        led_d     = init_pattern(shadow_mode_q);
                        dir_up_d  = 1'b1;
                    end else begin
                        unique case (mode_q)
                            2'd0: led_d = ~led_q;
                            2'd1: led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
                            2'd2: begin
                                led_d = bounce_next;
                                if (dir_up_q && bounce_next[NUM_LED-1]) dir_up_d = 1'b0;
                                if (!dir_up_q && bounce_next[0])        dir_up_d = 1'b1;
                            end
                            default: led_d = led_q + NUM_LED'(1);
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mode_q        <= 2'd0;
            rate_q        <= RateMax;
            shadow_mode_q <= 2'd0;
            shadow_rate_q <= RateMax;
            pending_q     <= 1'b0;
            led_q         <= '0;
            tick_q        <= 1'b0;
            dir_up_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            rate_q        <= rate_d;
            shadow_mode_q <= shadow_mode_d;
            shadow_rate_q <= shadow_rate_d;
            pending_q     <= pending_d;
            led_q         <= led_d;
            tick_q        <= tick_d;
            dir_up_q      <= dir_up_d;
        end
    end

    assign cfg.cfg_ready = !pending_q;
    assign led           = led_q;
    assign tick          = tick_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios followed by random stimulus, all
// compared every cycle against a reference model that tracks a step index and derives the
// LED pattern arithmetically from it.
module tb_led_seq_ctrl;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned NUM_LED = 8;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               hold;
    logic [NUM_LED-1:0] led;
    logic               tick;
    logic               busy;

    led_seq_ctrl_if cfg_bus ();

    led_seq_ctrl #(
        .CNT_W   (CNT_W),
        .NUM_LED (NUM_LED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .hold  (hold),
        .cfg   (cfg_bus),
        .led   (led),
        .tick  (tick),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    bit m_active;
    int m_k;
    int m_phase;
    int m_mode;
    int m_rate;
    bit m_pend;
    int m_smode;
    int m_srate;
    bit m_tick;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pattern(input int mode, input int k);
        int p;
        case (mode)
            0:       return (k % 2 == 1) ? (1 << NUM_LED) - 1 : 0;
            1:       return 1 << (k % NUM_LED);
            2: begin
                p = k % (2 * NUM_LED - 2);
                return (p < NUM_LED) ? (1 << p) : (1 << (2 * NUM_LED - 2 - p));
            end
            default: return k % (1 << NUM_LED);
        endcase
    endfunction

    function automatic int clamp(input int r);
        return (r > CNT_W - 1) ? CNT_W - 1 : r;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_k      = 0;
        m_phase  = 0;
        m_mode   = 0;
        m_rate   = CNT_W - 1;
        m_pend   = 0;
        m_smode  = 0;
        m_srate  = CNT_W - 1;
        m_tick   = 0;
    endtask

    task automatic model_edge();
        bit accept;
        bit old_pend;
        int cr;
        accept   = cfg_bus.cfg_valid && !m_pend;
        cr       = clamp(int'(cfg_bus.cfg_rate));
        old_pend = m_pend;
        m_tick   = 0;
        if (!en) begin
            if (accept) begin
                m_mode = int'(cfg_bus.cfg_mode);
                m_rate = cr;
            end else if (old_pend) begin
                m_mode = m_smode;
                m_rate = m_srate;
            end
            m_pend   = 0;
            m_active = 0;
            m_phase  = 0;
            m_k      = 0;
        end else if (!m_active) begin
            if (accept) begin
                m_mode = int'(cfg_bus.cfg_mode);
                m_rate = cr;
            end
            m_active = 1;
            m_phase  = 0;
            m_k      = 0;
        end else begin
            if (accept) begin
                m_smode = int'(cfg_bus.cfg_mode);
                m_srate = cr;
                m_pend  = 1;
            end
            if (!hold) begin
                if (m_phase == (1 << m_rate) - 1) begin
                    m_tick  = 1;
                    m_phase = 0;
                    if (old_pend) begin
                        m_mode = m_smode;
                        m_rate = m_srate;
                        m_pend = 0;
                        m_k    = 0;
                    end else begin
                        m_k++;
                    end
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    task automatic check_all(input string pfx);
        check_val({pfx, ".led"}, 32'(led), m_active ? 32'(pattern(m_mode, m_k)) : 32'd0);
        check_val({pfx, ".tick"}, 32'(tick), 32'(m_tick));
        check_val({pfx, ".busy"}, 32'(busy), 32'(m_active));
        check_val({pfx, ".ready"}, 32'(cfg_bus.cfg_ready), 32'(!m_pend));
    endtask

    task automatic step(input bit e, input bit h, input bit v, input int md, input int rt);
        @(negedge clk);
        en                = e;
        hold              = h;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_mode  = md[1:0];
        cfg_bus.cfg_rate  = rt[4:0];
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic run(input int n, input bit h);
        for (int i = 0; i < n; i++) step(1'b1, h, 1'b0, 0, 0);
    endtask

    // Asynchronous reset pulse taken mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        en                = 1'b0;
        hold              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n             = 1'b0;
        en                = 1'b0;
        hold              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_mode  = 2'd0;
        cfg_bus.cfg_rate  = 5'd0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Chase at rate 2: 01,02,04,... every 4 cycles, wrapping 0x80 -> 0x01.
        step(1'b0, 1'b0, 1'b1, 1, 2);
        run(40, 1'b0);

        // Bounce at rate 0: led steps every cycle with no repeated endpoint.
        step(1'b0, 1'b0, 1'b1, 2, 0);
        run(20, 1'b0);

        // Count at rate 3, then switch to blink mid-period.
        step(1'b0, 1'b0, 1'b1, 3, 3);
        run(13, 1'b0);
        step(1'b1, 1'b0, 1'b1, 0, 3);
        run(30, 1'b0);

        // Hold for 10 cycles mid-period.
        run(5, 1'b0);
        run(10, 1'b1);
        run(20, 1'b0);

        // en drops on a tick-due cycle at rate 0.
        step(1'b0, 1'b0, 1'b1, 1, 0);
        run(5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0);

        // Reset mid-run, then an oversize rate that must clamp to CNT_W-1.
        step(1'b0, 1'b0, 1'b1, 3, 1);
        run(9, 1'b0);
        pulse_reset();
        step(1'b0, 1'b0, 1'b1, 3, 31);
        run(100, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) pulse_reset();
            step(($urandom_range(0, 99) < 96),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 9)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

LED pattern sequencer for the tile's LED outputs. It owns the free-running prescaler counter, turns it into a programmable tick, and steps one of four LED patterns on each tick. Patterns are blink, chase, bounce and binary count. A valid/ready configuration port lets the top level change pattern and rate without glitches; changes apply only on tick boundaries while running.

## Interface
Parameters:
- CNT_W, 26, prescaler width; max tick period 2^(CNT_W-1) cycles
- NUM_LED, 8, LED output width (>= 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low forces IDLE
- hold  in  1  freeze prescaler and pattern while running
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_mode  in  2  0 blink, 1 chase, 2 bounce, 3 count
- cfg_rate  in  5  tick period exponent; period = 2^rate cycles
- led  out  NUM_LED  registered LED drive
- tick  out  1  one-cycle pulse, coincident with each led update
- busy  out  1  high when state != IDLE

## Operation
- States: IDLE, RUN, HOLD.
  - IDLE -> RUN when en=1.
  - RUN <-> HOLD follows hold.
  - Any state -> IDLE when en=0. This has top priority.
- Active registers are mode and rate. Rate is clamped to CNT_W-1 on accept.
- Prescaler behaviour:
  - IDLE: held at 0.
  - RUN: counts 0 .. 2^rate-1, then wraps to 0.
  - HOLD: frozen.
- Tick fires on the RUN-state edge where prescaler == 2^rate-1.
- Initial pattern, loaded on IDLE->RUN and on config apply:
  - blink: all 0
  - chase: bit 0
  - bounce: bit 0, direction up
  - count: 0
- Pattern step on each tick:
  - blink: invert all bits.
  - chase: rotate left by 1, wrapping MSB to bit 0.
  - bounce: shift toward the current direction. The direction reverses after reaching bit NUM_LED-1 or bit 0, so the sequence runs 0,1,..,N-1,N-2,..,0,1.
  - count: led + 1 modulo 2^NUM_LED.
- Config handshake: accepted when cfg_valid && cfg_ready.
  - In IDLE: written straight into the active registers. cfg_ready stays 1.
  - In RUN/HOLD: stored in a shadow register, pending=1, cfg_ready=0.
- Pending apply happens on the next tick edge. Instead of stepping:
  - led loads the new mode's initial pattern;
  - rate and mode update;
  - prescaler restarts at 0;
  - tick still pulses;
  - pending clears and cfg_ready returns to 1 on the following cycle.
- en=0 with pending config: the shadow is applied to the active registers on the same edge as entering IDLE.
- hold blocks tick. A pending config waits through HOLD.

## Timing
- Reset values:
  - led=0, tick=0, busy=0, cfg_ready=1
  - mode=0, rate=CNT_W-1
  - prescaler=0, pending=0, state IDLE
- en sampled high at edge E: busy=1 after E. The first tick and led update occur at edge E+2^rate.
- rate=0: tick high every RUN cycle, led steps every cycle.
- en low at edge E: after E, led=0, tick=0, busy=0 and prescaler=0, whatever the prescaler phase.
- hold high at edge E: the prescaler value after E equals its value before E. On release it resumes counting with no lost or extra count.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). Outputs are valid from the first clock after rst_n rises.
- Defaults reproduce the legacy blinker: blink mode, rate CNT_W-1, giving an LED period of 2^CNT_W cycles.

## Test plan
- Reset, then IDLE cfg (mode=1, rate=2), then en=1 -> led 01,02,04,... at 4-cycle spacing; tick pulses coincident; 0x80 -> 0x01 wrap.
- Bounce, rate=0, NUM_LED=8 -> led sequence 01,02,...,80,40,...,01,02 with no repeated endpoint.
- RUN in count mode, rate=3, then cfg mode=0 mid-period -> cfg_ready=0 until the next tick; at that tick led=00, prescaler restarts, later ticks invert led.
- hold asserted for 10 cycles mid-period -> no tick; the next tick arrives exactly 10 cycles late.
- en=0 on a tick-due cycle -> next cycle led=0, tick=0, busy=0.
- rst_n pulsed low mid-run -> all outputs at reset values immediately; rate=31 accepted -> clamped to CNT_W-1.
